// File: rtl/mdu_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: op codes, FSM
// encoding and the latency-class lookup used by the pipeline wrapper.
package mdu_pkg;

  localparam logic [3:0] MDU_NONE  = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MTHI  = 4'd5;
  localparam logic [3:0] MDU_MTLO  = 4'd6;
  localparam logic [3:0] MDU_MADD  = 4'd7;
  localparam logic [3:0] MDU_MADDU = 4'd8;
  localparam logic [3:0] MDU_MSUB  = 4'd9;
  localparam logic [3:0] MDU_MSUBU = 4'd10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  typedef enum logic [1:0] {
    CLS_NONE = 2'd0,
    CLS_MOVE = 2'd1,
    CLS_MULT = 2'd2,
    CLS_DIV  = 2'd3
  } mdu_class_e;

  function automatic mdu_class_e mdu_op_class(input logic [3:0] op);
    mdu_class_e cls;
    case (op)
      MDU_MULT, MDU_MULTU, MDU_MADD, MDU_MADDU,
      MDU_MSUB, MDU_MSUBU:  cls = CLS_MULT;
      MDU_DIV, MDU_DIVU:    cls = CLS_DIV;
      MDU_MTHI, MDU_MTLO:   cls = CLS_MOVE;
      default:              cls = CLS_NONE;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/mdu_core.sv
// Combinational result datapath: computes the HI/LO values an op would leave
// behind, given the operands and the current HI/LO.
module mdu_core
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] rs_i,
  input  logic [WIDTH-1:0] rt_i,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  output logic [WIDTH-1:0] next_hi_o,
  output logic [WIDTH-1:0] next_lo_o
);

  localparam int W2 = 2 * WIDTH;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic            signed_mul;
  logic [W2-1:0]   a_ext;
  logic [W2-1:0]   b_ext;
  logic [W2-1:0]   prod;
  logic [W2-1:0]   acc;
  logic [W2-1:0]   madd_res;
  logic [W2-1:0]   msub_res;

  // Sign/zero-extending to 2*WIDTH lets one unsigned multiplier serve both
  // flavours; the low 2*WIDTH bits are the correct product either way.
  always_comb begin
    signed_mul = (op_i == MDU_MULT) || (op_i == MDU_MADD) || (op_i == MDU_MSUB);
    a_ext = signed_mul ? {{WIDTH{rs_i[WIDTH-1]}}, rs_i} : {{WIDTH{1'b0}}, rs_i};
    b_ext = signed_mul ? {{WIDTH{rt_i[WIDTH-1]}}, rt_i} : {{WIDTH{1'b0}}, rt_i};
  end

  assign prod     = a_ext * b_ext;
  assign acc      = {hi_i, lo_i};
  assign madd_res = acc + prod;
  assign msub_res = acc - prod;

  logic             div_signed;
  logic             rs_neg;
  logic             rt_neg;
  logic             div_zero;
  logic             div_ovf;
  logic [WIDTH-1:0] rs_mag;
  logic [WIDTH-1:0] rt_mag;
  logic [WIDTH-1:0] rt_safe;
  logic [WIDTH-1:0] uq;
  logic [WIDTH-1:0] ur;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;

  // Signed divide runs on magnitudes so the divider never sees a zero or
  // overflowing signed pair; signs are reapplied afterwards.
  always_comb begin
    div_signed = (op_i == MDU_DIV);
    rs_neg     = div_signed & rs_i[WIDTH-1];
    rt_neg     = div_signed & rt_i[WIDTH-1];
    rs_mag     = rs_neg ? -rs_i : rs_i;
    rt_mag     = rt_neg ? -rt_i : rt_i;
    div_zero   = (rt_i == '0);
    div_ovf    = div_signed && (rs_i == MOST_NEG) && (rt_i == '1);
    rt_safe    = div_zero ? WIDTH'(1) : rt_mag;
    uq         = rs_mag / rt_safe;
    ur         = rs_mag % rt_safe;
    quot       = (rs_neg ^ rt_neg) ? -uq : uq;
    rem        = rs_neg ? -ur : ur;
  end

  always_comb begin
    next_hi_o = hi_i;
    next_lo_o = lo_i;
    case (op_i)
      MDU_MULT, MDU_MULTU: {next_hi_o, next_lo_o} = prod;
      MDU_MADD, MDU_MADDU: {next_hi_o, next_lo_o} = madd_res;
      MDU_MSUB, MDU_MSUBU: {next_hi_o, next_lo_o} = msub_res;
      MDU_DIV, MDU_DIVU: begin
        if (div_zero) begin
          next_hi_o = rs_i;
          next_lo_o = '1;
        end else if (div_ovf) begin
          next_hi_o = '0;
          next_lo_o = MOST_NEG;
        end else begin
          next_hi_o = rem;
          next_lo_o = quot;
        end
      end
      MDU_MTHI: next_hi_o = rs_i;
      MDU_MTLO: next_lo_o = rs_i;
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_pipe.sv
// E-stage multiply/divide unit: owns HI/LO, holds a long op's result in a
// pending buffer for a fixed latency, and reports busy to the hazard unit.
module mdu_pipe
  import mdu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             cancel,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  mdu_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] pend_hi_q, pend_hi_d;
  logic [WIDTH-1:0] pend_lo_q, pend_lo_d;

  logic [WIDTH-1:0] core_hi;
  logic [WIDTH-1:0] core_lo;
  mdu_class_e       op_cls;
  logic             accept;
  logic             launch;
  logic             last_cycle;

  mdu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .op_i      (op),
    .rs_i      (rs_val),
    .rt_i      (rt_val),
    .hi_i      (hi_q),
    .lo_i      (lo_q),
    .next_hi_o (core_hi),
    .next_lo_o (core_lo)
  );

  assign op_cls     = mdu_op_class(op);
  assign accept     = start && !cancel && (state_q == ST_IDLE);
  assign launch     = accept && ((op_cls == CLS_MULT) || (op_cls == CLS_DIV));
  assign last_cycle = (cnt_q == CW'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (launch) state_d = ST_RUN;
      ST_RUN:  if (cancel || last_cycle) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == ST_RUN);
  end

  // Cancel dominates both a same-cycle start and the commit edge.
  always_comb begin
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    if (state_q == ST_RUN) begin
      if (cancel) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q - CW'(1);
        if (last_cycle) begin
          hi_d = pend_hi_q;
          lo_d = pend_lo_q;
        end
      end
    end else if (accept) begin
      case (op_cls)
        CLS_MULT: begin
          pend_hi_d = core_hi;
          pend_lo_d = core_lo;
          cnt_d     = CW'(MULT_CYCLES);
        end
        CLS_DIV: begin
          pend_hi_d = core_hi;
          pend_lo_d = core_lo;
          cnt_d     = CW'(DIV_CYCLES);
        end
        CLS_MOVE: begin
          hi_d = core_hi;
          lo_d = core_lo;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: doc/mdu_pipe.md
Name: mdu_pipe

Overview:
- Parametrised multiply/divide unit for the E stage of the 5-stage MIPS pipeline.
- Supersedes the fixed-latency E-stage mult/div logic. Adds configurable width and per-class latency, multiply-accumulate modes, a flush/cancel input and defined divide corner cases.
- Owns the HI/LO registers. Drives busy, which the hazard unit combines with start to stall D.

Parameters:
- WIDTH, 32, operand/HI/LO width.
- MULT_CYCLES, 5, busy cycles for mult/madd/msub class (>=1).
- DIV_CYCLES, 10, busy cycles for div class (>=1).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low; reset==0 clears all state immediately.
- start  in  1  E-stage instruction is an MDU op this cycle.
- op  in  4  1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu, 9 msub, 10 msubu; any other code = no-op.
- rs_val  in  WIDTH  operand A (dividend / mthi-mtlo source).
- rt_val  in  WIDTH  operand B (divisor).
- cancel  in  1  flush: abort the in-flight op and discard any same-cycle start.
- busy  out  1  long op in flight.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (reset==0, asynchronous): hi=0, lo=0, busy=0, counter=0, pending result cleared.
- FSM states: IDLE, RUN.
- IDLE:
  - start & ~cancel & long op (1-4, 7-10): latch the computed result into pending hi/lo, load counter with the class latency, go to RUN. busy=1 from the next cycle.
  - start & ~cancel & mthi/mtlo: write hi (or lo) = rs_val at that edge. No busy, stay IDLE.
  - No-op codes are ignored.
- RUN:
  - Counter decrements each cycle. busy stays high exactly MULT_CYCLES or DIV_CYCLES cycles.
  - On the edge where counter reaches 1, pending values commit to hi/lo, busy=0, return to IDLE.
  - New hi/lo values are visible in the first cycle busy reads 0.
- start while busy: ignored; the hazard unit must stall. No state change, including for mthi/mtlo.
- cancel:
  - In RUN: go to IDLE at the next edge, busy=0, hi/lo keep their pre-op values.
  - In IDLE: the same-cycle start is discarded.
  - cancel together with start: cancel wins.
  - cancel on the commit edge: cancel wins, no commit.
- Arithmetic:
  - mult/madd/msub: signed 2*WIDTH product.
  - multu/maddu/msubu: unsigned 2*WIDTH product.
  - madd family: {hi,lo} += product, wrapping modulo 2^(2*WIDTH).
  - msub family: {hi,lo} -= product, wrapping modulo 2^(2*WIDTH).
  - Accumulate operands are {hi,lo} sampled at start. Inputs are sampled only at start; later operand changes have no effect.
  - div: signed, truncates toward zero; lo=quotient, hi=remainder, remainder takes the dividend's sign.
  - divu: unsigned.
- Divide corner cases:
  - Divide by zero (both div and divu): lo = all ones, hi = rs_val.
  - Signed overflow (div of most-negative by -1): lo = most-negative, hi = 0.
  - Neither case raises an exception.
- Back-to-back: a new start is accepted in the first cycle busy reads 0.
- Reset mid-operation: immediate return to the reset state; the pending result is lost.

Decomposition:
- Shared package mdu_pkg: op-code localparams (MDU_NONE..MDU_MSUBU), state encoding, and a function giving the latency class of an op.
- One sub-module, mdu_core: purely combinational result calculation from op, rs, rt, hi, lo. It produces next_hi and next_lo, including the divide corner cases.
- mdu_pipe owns the FSM, the latency counter, the pending registers and HI/LO.

Test Plan:
- Signed multiply: mult rs=0xFFFFFFFE (-2), rt=3 → busy high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- Unsigned divide then divide by zero:
  - divu rs=100, rt=7 → after 10 busy cycles lo=14, hi=2.
  - divu rs=5, rt=0 → lo=0xFFFFFFFF, hi=5.
- Signed divide corner cases:
  - div rs=0x80000000, rt=0xFFFFFFFF → lo=0x80000000, hi=0.
  - div rs=-7, rt=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Move, then accumulate with wrap:
  - mthi 0xFFFFFFFF and mtlo 0xFFFFFFFF → take effect next edge, busy stays 0.
  - maddu rs=1, rt=1 → hi=0, lo=0 (wrap).
- Cancel and start-while-busy:
  - mult 3x4 with cancel asserted in busy cycle 3 → busy=0 next cycle, hi/lo unchanged.
  - start of divu during busy → ignored, result equals the first op only.
- Asynchronous reset: assert reset=0 mid-DIV at a non-clock-edge time → busy=0, hi=lo=0 immediately; release, then mult 2x2 → lo=4 after 5 cycles.
- Non-default parameters: rerun the first and fourth scenarios with MULT_CYCLES=1, DIV_CYCLES=3, WIDTH=16 and check busy lengths and results.
